// File: rtl/vp_pkg.sv
// ---------------------------------------------------------------------------
// vp_pkg
//
// Definitions shared by the shader pipelines, the vector-processor arbiter and
// the vector processor itself:
//   - default lane width (8.8 fixed point) and lanes per vector
//   - op-code width and the op-code constants used by the shader pipeline
//   - arbiter FSM state encoding (also exported on the arbiter debug port)
// ---------------------------------------------------------------------------
package vp_pkg;

    localparam int VP_DATA_WIDTH   = 16;
    localparam int VP_VECTOR_WIDTH = 4;
    localparam int VP_OP_WIDTH     = 4;

    localparam logic [VP_OP_WIDTH-1:0] OP_SCALE  = 4'h4;
    localparam logic [VP_OP_WIDTH-1:0] OP_LENGTH = 4'h5;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin picker. The winner is the first requester with
// its request bit set, searching upward from last_grant+1 modulo NUM_REQ.
// The previous winner itself therefore has the lowest priority.
//
// Ports:
//   req        in   NUM_REQ  request vector
//   last_grant in   IDX_W    index of the most recently served requester
//   grant      out  NUM_REQ  one-hot winner (all zero when no request)
//   grant_idx  out  IDX_W    index of the winner (0 when no request)
//   any_req    out  1        at least one request is present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest candidate to the nearest one so that the
    // nearest requesting index after last_grant overwrites everything else.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = cand;
                any_req     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vp_arbiter.sv
// ---------------------------------------------------------------------------
// vp_arbiter
//
// Shares one vector processor between NUM_REQ shader pipelines. One operation
// is in flight at a time: accept (IDLE) -> start pulse (ISSUE) -> wait for the
// result (WAIT) -> return it to the granted requester only (RESP).
//
// Handshake: a requester raises req_valid[i] and holds its payload stable
// until it sees req_ready[i]; the transfer happens in the cycle where both
// are high. Dropping req_valid before that withdraws the request. req_ready
// is a one-cycle one-hot pulse and is only ever raised in IDLE. resp_valid is
// a one-cycle one-hot strobe with no back-pressure; resp_error qualifies it.
//
// Optional feature macro: VP_ARB_TIMEOUT_EN
//   defined   - WAIT is bounded by a watchdog of TIMEOUT_CYCLES; on expiry
//               the requester gets resp_result=0 with resp_error=1.
//   undefined - WAIT waits for vp_result_valid indefinitely; resp_error=0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake
//   req_operation         4-bit op code per requester, [4i+3:4i]
//   req_vec_a/req_vec_b   operand vectors per requester
//   req_scalar            scalar operand per requester
//   resp_valid            one-hot result strobe
//   resp_result           shared result bus, held until the next RESP
//   resp_error            high with resp_valid when the operation timed out
//   vp_start              one-cycle start pulse to the vector processor
//   vp_operation/vp_vec_a/vp_vec_b/vp_scalar
//                         latched operands, held until the next acceptance
//   vp_busy               vector processor busy; blocks acceptance in IDLE
//   vp_done               status only; never completes an operation
//   vp_result_valid       result strobe, only honoured in WAIT
//   vp_result             result vector
//   dbg_state             current FSM state
// ---------------------------------------------------------------------------
module vp_arbiter
    import vp_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = VP_DATA_WIDTH,
    parameter int VECTOR_WIDTH   = VP_VECTOR_WIDTH,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_REQ-1:0]                       req_valid,
    output logic [NUM_REQ-1:0]                       req_ready,
    input  logic [NUM_REQ*VP_OP_WIDTH-1:0]           req_operation,
    input  logic [NUM_REQ*VECTOR_WIDTH*DATA_WIDTH-1:0] req_vec_a,
    input  logic [NUM_REQ*VECTOR_WIDTH*DATA_WIDTH-1:0] req_vec_b,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]            req_scalar,
    output logic [NUM_REQ-1:0]                       resp_valid,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]       resp_result,
    output logic                                     resp_error,
    output logic                                     vp_start,
    output logic [VP_OP_WIDTH-1:0]                   vp_operation,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]       vp_vec_a,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]       vp_vec_b,
    output logic [DATA_WIDTH-1:0]                    vp_scalar,
    input  logic                                     vp_busy,
    input  logic                                     vp_done,
    input  logic                                     vp_result_valid,
    input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]       vp_result,
    output arb_state_e                               dbg_state
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int VEC_W = VECTOR_WIDTH * DATA_WIDTH;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_e               state_q, state_d;
    logic [IDX_W-1:0]         grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]         last_grant_q, last_grant_d;
    logic [VP_OP_WIDTH-1:0]   vp_operation_q, vp_operation_d;
    logic [VEC_W-1:0]         vp_vec_a_q, vp_vec_a_d;
    logic [VEC_W-1:0]         vp_vec_b_q, vp_vec_b_d;
    logic [DATA_WIDTH-1:0]    vp_scalar_q, vp_scalar_d;
    logic [VEC_W-1:0]         resp_result_q, resp_result_d;

`ifdef VP_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic                     resp_error_q, resp_error_d;
`endif

    // ------------------------------------------------------------------
    // Round-robin pick and payload selection
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]       pick_grant;
    logic [IDX_W-1:0]         pick_idx;
    logic                     pick_any;

    logic [VP_OP_WIDTH-1:0]   sel_op;
    logic [VEC_W-1:0]         sel_vec_a;
    logic [VEC_W-1:0]         sel_vec_b;
    logic [DATA_WIDTH-1:0]    sel_scalar;

    logic [NUM_REQ-1:0]       req_ready_c;
    logic [NUM_REQ-1:0]       resp_valid_c;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .grant_idx  (pick_idx),
        .any_req    (pick_any)
    );

    // The pick is one-hot, so a plain priority loop acts as a one-hot mux.
    always_comb begin
        sel_op     = '0;
        sel_vec_a  = '0;
        sel_vec_b  = '0;
        sel_scalar = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_op     = req_operation[i*VP_OP_WIDTH +: VP_OP_WIDTH];
                sel_vec_a  = req_vec_a[i*VEC_W +: VEC_W];
                sel_vec_b  = req_vec_b[i*VEC_W +: VEC_W];
                sel_scalar = req_scalar[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        grant_idx_d    = grant_idx_q;
        last_grant_d   = last_grant_q;
        vp_operation_d = vp_operation_q;
        vp_vec_a_d     = vp_vec_a_q;
        vp_vec_b_d     = vp_vec_b_q;
        vp_scalar_d    = vp_scalar_q;
        resp_result_d  = resp_result_q;
        req_ready_c    = '0;
`ifdef VP_ARB_TIMEOUT_EN
        timer_d        = timer_q;
        resp_error_d   = resp_error_q;
`endif

        case (state_q)
            ARB_IDLE: begin
                if (pick_any && !vp_busy) begin
                    req_ready_c    = pick_grant;
                    grant_idx_d    = pick_idx;
                    vp_operation_d = sel_op;
                    vp_vec_a_d     = sel_vec_a;
                    vp_vec_b_d     = sel_vec_b;
                    vp_scalar_d    = sel_scalar;
                    state_d        = ARB_ISSUE;
`ifdef VP_ARB_TIMEOUT_EN
                    resp_error_d   = 1'b0;
`endif
                end
            end

            ARB_ISSUE: begin
                state_d = ARB_WAIT;
`ifdef VP_ARB_TIMEOUT_EN
                // Clearing here means the counter reads 0 in the first
                // WAIT cycle.
                timer_d = '0;
`endif
            end

            ARB_WAIT: begin
                if (vp_result_valid) begin
                    resp_result_d = vp_result;
                    state_d       = ARB_RESP;
                end
`ifdef VP_ARB_TIMEOUT_EN
                else if (timer_q == TMR_W'(TIMEOUT_CYCLES)) begin
                    resp_result_d = '0;
                    resp_error_d  = 1'b1;
                    state_d       = ARB_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
`endif
            end

            ARB_RESP: begin
                last_grant_d = grant_idx_q;
                state_d      = ARB_IDLE;
            end

            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        resp_valid_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid_c[i] = (state_q == ARB_RESP) && (grant_idx_q == IDX_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ARB_IDLE;
            grant_idx_q    <= '0;
            last_grant_q   <= IDX_W'(NUM_REQ - 1);
            vp_operation_q <= '0;
            vp_vec_a_q     <= '0;
            vp_vec_b_q     <= '0;
            vp_scalar_q    <= '0;
            resp_result_q  <= '0;
        end else begin
            state_q        <= state_d;
            grant_idx_q    <= grant_idx_d;
            last_grant_q   <= last_grant_d;
            vp_operation_q <= vp_operation_d;
            vp_vec_a_q     <= vp_vec_a_d;
            vp_vec_b_q     <= vp_vec_b_d;
            vp_scalar_q    <= vp_scalar_d;
            resp_result_q  <= resp_result_d;
        end
    end

`ifdef VP_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q      <= '0;
            resp_error_q <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            resp_error_q <= resp_error_d;
        end
    end

    assign resp_error = resp_error_q;
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES[0];
    assign resp_error     = 1'b0;
`endif

    // vp_done is informational only: completion is signalled by
    // vp_result_valid alone.
    logic unused_vp_done;
    assign unused_vp_done = vp_done;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // req_ready is decoded from IDLE, which is also the reset state; masking
    // with rst_n keeps it low while reset is held with requests pending.
    assign req_ready    = req_ready_c & {NUM_REQ{rst_n}};
    assign resp_valid   = resp_valid_c;
    assign resp_result  = resp_result_q;
    assign vp_start     = (state_q == ARB_ISSUE);
    assign vp_operation = vp_operation_q;
    assign vp_vec_a     = vp_vec_a_q;
    assign vp_vec_b     = vp_vec_b_q;
    assign vp_scalar    = vp_scalar_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_vp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vp_arbiter
//
// Bench for vp_arbiter with NUM_REQ=4. A small vector-processor model answers
// each vp_start after vp_lat cycles with a result derived from the operands
// it was handed; the bench predicts that result from the payload it drove.
// Define VP_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=8).
// ---------------------------------------------------------------------------
module tb_vp_arbiter;
    import vp_pkg::*;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int VW  = 4;
    localparam int VEC = VW * DW;
    localparam int EW  = VEC + 4;    // {err, idx[2:0], result}

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*4-1:0]    req_operation;
    logic [N*VEC-1:0]  req_vec_a;
    logic [N*VEC-1:0]  req_vec_b;
    logic [N*DW-1:0]   req_scalar;
    logic [N-1:0]      resp_valid;
    logic [VEC-1:0]    resp_result;
    logic              resp_error;
    logic              vp_start;
    logic [3:0]        vp_operation;
    logic [VEC-1:0]    vp_vec_a;
    logic [VEC-1:0]    vp_vec_b;
    logic [DW-1:0]     vp_scalar;
    logic              vp_busy     = 1'b0;
    logic              vp_done     = 1'b0;
    logic              vp_rv_model = 1'b0;
    logic              vp_rv_stray = 1'b0;
    logic [VEC-1:0]    vp_result   = '0;
    arb_state_e        dbg_state;

    logic [3:0]        p_op [N];
    logic [VEC-1:0]    p_a  [N];
    logic [VEC-1:0]    p_b  [N];
    logic [DW-1:0]     p_s  [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_operation[i*4 +: 4]  = p_op[i];
            req_vec_a[i*VEC +: VEC]  = p_a[i];
            req_vec_b[i*VEC +: VEC]  = p_b[i];
            req_scalar[i*DW +: DW]   = p_s[i];
        end
    end

    vp_arbiter #(
        .NUM_REQ        (N),
        .DATA_WIDTH     (DW),
        .VECTOR_WIDTH   (VW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_operation   (req_operation),
        .req_vec_a       (req_vec_a),
        .req_vec_b       (req_vec_b),
        .req_scalar      (req_scalar),
        .resp_valid      (resp_valid),
        .resp_result     (resp_result),
        .resp_error      (resp_error),
        .vp_start        (vp_start),
        .vp_operation    (vp_operation),
        .vp_vec_a        (vp_vec_a),
        .vp_vec_b        (vp_vec_b),
        .vp_scalar       (vp_scalar),
        .vp_busy         (vp_busy),
        .vp_done         (vp_done),
        .vp_result_valid (vp_rv_model | vp_rv_stray),
        .vp_result       (vp_result),
        .dbg_state       (dbg_state)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check_eq(input string tag, input logic [EW-1:0] got,
                            input logic [EW-1:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [VEC-1:0] vp_func(input logic [3:0] op,
                                               input logic [VEC-1:0] a,
                                               input logic [VEC-1:0] b,
                                               input logic [DW-1:0] s);
        return (a + b) ^ {VW{s}} ^ {{(VEC-4){1'b0}}, op};
    endfunction

    // ------------------------------------------------------------------
    // Vector-processor model
    // ------------------------------------------------------------------
    int             vp_lat      = 3;
    bit             vp_model_en = 1'b1;
    bit             m_pending   = 1'b0;
    int             m_cnt       = 0;
    logic [VEC-1:0] m_res;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_pending = 1'b0;
            end else if (vp_start && vp_model_en) begin
                m_pending = 1'b1;
                m_cnt     = vp_lat;
                m_res     = vp_func(vp_operation, vp_vec_a, vp_vec_b, vp_scalar);
            end
            @(posedge clk);
            #1;
            vp_rv_model = 1'b0;
            if (m_pending && rst_n) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    vp_rv_model = 1'b1;
                    vp_result   = m_res;
                    m_pending   = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard / monitor (samples on the falling edge)
    // ------------------------------------------------------------------
    logic [EW-1:0] exp_q[$];
    int            grant_log[$];
    int            grant_cnt      = 0;
    int            resp_cnt       = 0;
    int            last_ready_cyc = -1;
    int            last_start_cyc = -1;
    int            last_resp_cyc  = -1;
    logic [EW-1:0] mon_e;
    logic [N-1:0]  mon_oh;
    int            mon_gi;

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != '0) begin
                check_eq("ready_onehot", EW'($onehot(req_ready)), EW'(1));
                mon_gi = -1;
                for (int i = 0; i < N; i++) if (req_ready[i]) mon_gi = i;
                grant_log.push_back(mon_gi);
                grant_cnt++;
                last_ready_cyc = cyc;
            end
            if (vp_start) last_start_cyc = cyc;
            if (resp_valid != '0) begin
                resp_cnt++;
                last_resp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("resp_unexpected", EW'(resp_valid), EW'(0));
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_oh = '0;
                    mon_oh[mon_e[VEC +: 2]] = 1'b1;
                    check_eq("resp_valid", EW'(resp_valid), EW'(mon_oh));
                    check_eq("resp_result", EW'(resp_result), EW'(mon_e[VEC-1:0]));
                    check_eq("resp_error", EW'(resp_error), EW'(mon_e[EW-1]));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_payload(input int i, input logic [3:0] op, input logic [DW-1:0] s);
        p_op[i] = op;
        p_a[i]  = {$urandom, $urandom};
        p_b[i]  = {$urandom, $urandom};
        p_s[i]  = s;
    endtask

    task automatic push_exp(input int i, input logic err, input logic [VEC-1:0] res);
        exp_q.push_back({err, 3'(i), res});
    endtask

    task automatic push_model_exp(input int i);
        push_exp(i, 1'b0, vp_func(p_op[i], p_a[i], p_b[i], p_s[i]));
    endtask

    task automatic wait_grants(input int target, input int budget, input string tag);
        int n = 0;
        while (grant_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        if (grant_cnt < target) check_eq(tag, EW'(grant_cnt), EW'(target));
    endtask

    task automatic wait_resps(input int target, input int budget, input string tag);
        int n = 0;
        while (resp_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        if (resp_cnt < target) check_eq(tag, EW'(resp_cnt), EW'(target));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int             rr_exp [5] = '{0, 1, 2, 3, 0};
    int             base;
    int             t0;
    logic [VEC-1:0] single_res;

    initial begin
        for (int i = 0; i < N; i++) set_payload(i, 4'(i), 16'($urandom_range(0, 65535)));

        // Reset values
        rst_n = 1'b0;
        step(3);
        @(negedge clk);
        check_eq("rst_req_ready", EW'(req_ready), EW'(0));
        check_eq("rst_resp_valid", EW'(resp_valid), EW'(0));
        check_eq("rst_resp_result", EW'(resp_result), EW'(0));
        check_eq("rst_resp_error", EW'(resp_error), EW'(0));
        check_eq("rst_vp_start", EW'(vp_start), EW'(0));
        check_eq("rst_vp_operation", EW'(vp_operation), EW'(0));
        check_eq("rst_vp_vec_a", EW'(vp_vec_a), EW'(0));
        check_eq("rst_vp_scalar", EW'(vp_scalar), EW'(0));
        step(1);
        rst_n = 1'b1;

        // All four requesting from reset: order 0,1,2,3,0
        vp_lat = 2;
        for (int k = 0; k < 5; k++) push_model_exp(rr_exp[k]);
        req_valid = 4'hF;
        wait_grants(5, 80, "rr_grant_timeout");
        req_valid = '0;
        wait_resps(5, 80, "rr_resp_timeout");
        for (int k = 0; k < 5; k++)
            check_eq($sformatf("rr_order%0d", k), EW'(grant_log[k]), EW'(rr_exp[k]));
        step(2);

        // Single request, vp latency 3
        vp_lat = 3;
        set_payload(2, OP_SCALE, 16'h0100);
        single_res = vp_func(p_op[2], p_a[2], p_b[2], p_s[2]);
        push_exp(2, 1'b0, single_res);
        base      = grant_cnt;
        t0        = cyc;
        req_valid = 4'b0100;
        wait_grants(base + 1, 20, "single_grant_timeout");
        req_valid = '0;
        wait_resps(resp_cnt + 1, 20, "single_resp_timeout");
        check_eq("single_ready_cyc", EW'(last_ready_cyc - t0), EW'(0));
        check_eq("single_grant_idx", EW'(grant_log[grant_log.size()-1]), EW'(2));
        check_eq("single_start_lat", EW'(last_start_cyc - last_ready_cyc), EW'(1));
        check_eq("single_resp_lat", EW'(last_resp_cyc - last_ready_cyc), EW'(5));
        check_eq("single_vp_op", EW'(vp_operation), EW'(OP_SCALE));
        check_eq("single_vp_scalar", EW'(vp_scalar), EW'(16'h0100));
        step(3);
        check_eq("result_hold", EW'(resp_result), EW'(single_res));

        // vp_busy blocks acceptance for 10 cycles
        set_payload(1, OP_LENGTH, 16'($urandom_range(0, 65535)));
        push_model_exp(1);
        base      = grant_cnt;
        vp_busy   = 1'b1;
        req_valid = 4'b0010;
        step(10);
        check_eq("busy_block", EW'(grant_cnt), EW'(base));
        vp_busy = 1'b0;
        t0      = cyc;
        wait_grants(base + 1, 20, "busy_grant_timeout");
        req_valid = '0;
        check_eq("busy_release_cyc", EW'(last_ready_cyc - t0), EW'(0));
        wait_resps(resp_cnt + 1, 20, "busy_resp_timeout");
        step(2);

        // Stray vp_result_valid in IDLE, vp_done alone in WAIT
        base        = resp_cnt;
        vp_rv_stray = 1'b1;
        step(1);
        vp_rv_stray = 1'b0;
        step(3);
        check_eq("stray_no_resp", EW'(resp_cnt), EW'(base));
        vp_lat = 6;
        set_payload(3, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)));
        push_model_exp(3);
        base      = grant_cnt;
        req_valid = 4'b1000;
        wait_grants(base + 1, 20, "done_grant_timeout");
        req_valid = '0;
        step(2);
        vp_done = 1'b1;
        step(1);
        vp_done = 1'b0;
        wait_resps(resp_cnt + 1, 30, "done_resp_timeout");
        check_eq("done_ignored_lat", EW'(last_resp_cyc - last_start_cyc), EW'(7));
        step(2);

        // Reset during WAIT, then tie between requesters 0 and 3
        vp_lat = 20;
        set_payload(0, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)));
        set_payload(3, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)));
        base      = grant_cnt;
        req_valid = 4'b1000;
        wait_grants(base + 1, 20, "rst_grant_timeout");
        req_valid = 4'b1001;
        step(3);
        check_eq("pre_rst_state", EW'(dbg_state), EW'(ARB_WAIT));
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_req_ready", EW'(req_ready), EW'(0));
        check_eq("midrst_resp_valid", EW'(resp_valid), EW'(0));
        check_eq("midrst_vp_start", EW'(vp_start), EW'(0));
        check_eq("midrst_vp_operation", EW'(vp_operation), EW'(0));
        check_eq("midrst_vp_vec_b", EW'(vp_vec_b), EW'(0));
        check_eq("midrst_resp_result", EW'(resp_result), EW'(0));
        check_eq("midrst_state", EW'(dbg_state), EW'(ARB_IDLE));
        step(2);
        vp_lat = 2;
        push_model_exp(0);
        base  = resp_cnt;
        t0    = grant_cnt;
        rst_n = 1'b1;
        wait_grants(t0 + 1, 20, "tie_grant_timeout");
        req_valid = '0;
        check_eq("tie_winner", EW'(grant_log[grant_log.size()-1]), EW'(0));
        wait_resps(base + 1, 20, "tie_resp_timeout");
        step(3);
        check_eq("tie_single_resp", EW'(resp_cnt), EW'(base + 1));

`ifdef VP_ARB_TIMEOUT_EN
        // Watchdog: vp never answers
        vp_model_en = 1'b0;
        set_payload(1, OP_SCALE, 16'($urandom_range(0, 65535)));
        push_exp(1, 1'b1, '0);
        base      = grant_cnt;
        req_valid = 4'b0010;
        wait_grants(base + 1, 20, "to_grant_timeout");
        req_valid = '0;
        wait_resps(resp_cnt + 1, 40, "to_resp_timeout");
        check_eq("to_resp_lat", EW'(last_resp_cyc - last_start_cyc), EW'(10));
        step(2);
        vp_model_en = 1'b1;
        set_payload(2, OP_LENGTH, 16'($urandom_range(0, 65535)));
        push_model_exp(2);
        base      = grant_cnt;
        req_valid = 4'b0100;
        wait_grants(base + 1, 20, "after_to_grant_timeout");
        req_valid = '0;
        check_eq("after_to_error_clr", EW'(resp_error), EW'(0));
        wait_resps(resp_cnt + 1, 20, "after_to_resp_timeout");
        step(2);
`endif

        step(3);
        check_eq("queue_drained", EW'(exp_q.size()), EW'(0));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "bench watchdog expired");
    end

endmodule
